ulpi_rx_pck: RTL

- Receive-side stage of the ULPI block; runs while the ULPI controller is in its packet-receive state (PHY owns the bus, DIR high).
- Samples ULPI_DATA/NXT/DIR and separates RX CMD bytes from USB packet bytes.
- Keeps the PHY status registers (LineState, Vbus, RxEvent, ID, alt_int) current.
- Pushes packet bytes, tagged with sop/eop/err, into a small FIFO that the downstream sniffer logic drains with a valid/ready handshake.

---
 rtl/ulpi_rx_pck_if.sv | 25 ++
 rtl/ulpi_rx_pck.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ulpi_rx_pck_if.sv
// ulpi_rx_pck_if: groups the ULPI receive-side bus (DIR/NXT/data as sampled
// from the PHY) with the downstream byte stream (RX_* valid/ready).
//   master : the receive stage; samples ULPI, drives the RX_* stream
//   slave  : the PHY model plus the stream consumer; drives ULPI and RX_READY
interface ulpi_rx_pck_if;
    logic       DIR;
    logic       NXT;
    logic [7:0] ULPI_DATA_IN;
    logic [7:0] RX_DATA;
    logic       RX_SOP;
    logic       RX_EOP;
    logic       RX_ERR;
    logic       RX_VALID;
    logic       RX_READY;

    modport master (
        input  DIR, NXT, ULPI_DATA_IN, RX_READY,
        output RX_DATA, RX_SOP, RX_EOP, RX_ERR, RX_VALID
    );

    modport slave (
        output DIR, NXT, ULPI_DATA_IN, RX_READY,
        input  RX_DATA, RX_SOP, RX_EOP, RX_ERR, RX_VALID
    );
endinterface

// File: rtl/ulpi_rx_pck.sv
// ulpi_rx_pck: ULPI receive stage. While the PHY owns the bus (DIR high) each
// cycle is split into RX CMD bytes (NXT=0) and packet bytes (NXT=1). RX CMDs
// refresh the PHY status outputs; packet bytes are staged one deep so the last
// byte can be tagged eop when the close event arrives, then pushed into a small
// FIFO drained with RX_VALID/RX_READY.
// Ports:
//   clk_ext, rst       : PHY clock, synchronous active-low reset
//   bus (master)       : DIR/NXT/ULPI_DATA_IN in, RX_* stream out, RX_READY in
//   LINESTATE..ALT_INT : fields of the last RX CMD
//   PCK_DONE, PCK_LEN  : close pulse and byte count of last closed packet
//   OVF, OVF_CLR       : sticky FIFO overflow flag and its clear
//   BUSY               : state != IDLE (also high in SKIP after reset)
//
// state    | meaning
// SKIP     | after reset, wait for DIR low so a transfer in flight is not parsed
// IDLE     | link owns the bus, waiting for DIR rise
// TURN_IN  | turnaround cycle after DIR rise, data ignored
// RECV     | PHY drives RX CMD / packet bytes
// TURN_OUT | turnaround cycle after DIR fall, data ignored
module ulpi_rx_pck #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 11
) (
    input  logic             clk_ext,
    input  logic             rst,
    ulpi_rx_pck_if.master    bus,
    output logic [1:0]       LINESTATE,
    output logic [1:0]       VBUS,
    output logic             RX_ACTIVE,
    output logic             HOST_DISC,
    output logic             ID,
    output logic             ALT_INT,
    output logic             PCK_DONE,
    output logic [LEN_W-1:0] PCK_LEN,
    output logic             OVF,
    input  logic             OVF_CLR,
    output logic             BUSY
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 11;                   // {err, eop, sop, data}

    typedef enum logic [2:0] {S_SKIP, S_IDLE, S_TURN_IN, S_RECV, S_TURN_OUT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         rxcmd_q, rxcmd_d;
    logic [7:0]         stage_q, stage_d;
    logic               stage_sop_q, stage_sop_d;
    // A packet is open exactly when a byte is staged, so one flag covers both.
    logic               pkt_open_q, pkt_open_d;
    logic               err_q, err_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   pck_len_q, pck_len_d;
    logic               pck_done_q, pck_done_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];

    logic               close, push, pop, full, empty, accept;
    logic [ENT_W-1:0]   push_ent, head_ent;
    logic [PTR_W:0]     fill;

    always_comb begin
        state_d     = state_q;
        rxcmd_d     = rxcmd_q;
        stage_d     = stage_q;
        stage_sop_d = stage_sop_q;
        pkt_open_d  = pkt_open_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        pck_len_d   = pck_len_q;
        pck_done_d  = 1'b0;
        close       = 1'b0;
        push        = 1'b0;
        push_ent    = '0;

        case (state_q)
            S_SKIP:     if (!bus.DIR) state_d = S_IDLE;
            S_IDLE:     if (bus.DIR) state_d = S_TURN_IN;
            S_TURN_IN:  state_d = bus.DIR ? S_RECV : S_IDLE;
            S_RECV: begin
                if (!bus.DIR) begin
                    state_d = S_TURN_OUT;
                    close   = 1'b1;
                end else if (!bus.NXT) begin
                    rxcmd_d = bus.ULPI_DATA_IN;
                    if (bus.ULPI_DATA_IN[5:4] == 2'b11) err_d = 1'b1;
                    // RxActive low ends reception; RxEvent 11 has RxActive high
                    // so the error flag and a close never coincide.
                    if (!bus.ULPI_DATA_IN[4]) close = 1'b1;
                end else begin
                    if (pkt_open_q) begin
                        push     = 1'b1;
                        push_ent = {1'b0, 1'b0, stage_sop_q, stage_q};
                        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
                    end else begin
                        cnt_d    = LEN_W'(1);
                    end
                    stage_d     = bus.ULPI_DATA_IN;
                    stage_sop_d = !pkt_open_q;
                    pkt_open_d  = 1'b1;
                end
            end
            S_TURN_OUT: state_d = bus.DIR ? S_TURN_IN : S_IDLE;
            default:    state_d = S_SKIP;
        endcase

        // A close with nothing staged only clears the packet context.
        if (close) begin
            if (pkt_open_q) begin
                push       = 1'b1;
                push_ent   = {err_q, 1'b1, stage_sop_q, stage_q};
                pck_done_d = 1'b1;
                pck_len_d  = cnt_q;
            end
            pkt_open_d = 1'b0;
            err_d      = 1'b0;
            cnt_d      = '0;
        end
    end

    // FIFO: a push into a full FIFO is kept only if the head leaves this cycle.
    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        full     = (fill == (PTR_W+1)'(FIFO_DEPTH));
        empty    = (fill == '0);
        pop      = !empty && bus.RX_READY;
        accept   = push && (!full || pop);
        mem_d    = mem_q;
        if (accept) mem_d[wr_ptr_q[PTR_W-1:0]] = push_ent;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(accept);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
        ovf_d    = (push && full && !pop) || (ovf_q && !OVF_CLR);
        head_ent = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk_ext) begin
        if (!rst) begin
            state_q     <= S_SKIP;
            rxcmd_q     <= '0;
            stage_q     <= '0;
            stage_sop_q <= 1'b0;
            pkt_open_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            pck_len_q   <= '0;
            pck_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            rxcmd_q     <= rxcmd_d;
            stage_q     <= stage_d;
            stage_sop_q <= stage_sop_d;
            pkt_open_q  <= pkt_open_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            pck_len_q   <= pck_len_d;
            pck_done_q  <= pck_done_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only visible through a non-empty head.
    always_ff @(posedge clk_ext) begin
        mem_q <= mem_d;
    end

    assign bus.RX_DATA  = head_ent[7:0];
    assign bus.RX_SOP   = head_ent[8];
    assign bus.RX_EOP   = head_ent[9];
    assign bus.RX_ERR   = head_ent[10];
    assign bus.RX_VALID = !empty;

    assign LINESTATE = rxcmd_q[1:0];
    assign VBUS      = rxcmd_q[3:2];
    assign RX_ACTIVE = rxcmd_q[4];
    assign HOST_DISC = (rxcmd_q[5:4] == 2'b10);
    assign ID        = rxcmd_q[6];
    assign ALT_INT   = rxcmd_q[7];
    assign PCK_DONE  = pck_done_q;
    assign PCK_LEN   = pck_len_q;
    assign OVF       = ovf_q;
    assign BUSY      = (state_q != S_IDLE);
endmodule
